// File: rtl/ifu_fetch_queue_if.sv
// Fetch-stage bus bundle: PC request, flush, memory port and decoder handoff.
// slave = fetch queue view, master = surrounding pipeline / memory view.
interface ifu_fetch_queue_if #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32
);
    logic [ADDR_W-1:0]  instr_req_pc;
    logic               instr_req_vld;
    logic               instr_req_rdy;
    logic               flush_i;
    logic               mem_req_vld;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic               mem_req_rdy;
    logic               mem_rsp_vld;
    logic [INSTR_W-1:0] mem_rsp_data;
    logic               dec_vld;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0]  dec_pc;
    logic               dec_rdy;
    logic               fetch_busy_o;

    modport slave (
        input  instr_req_pc, instr_req_vld, flush_i, mem_req_rdy,
               mem_rsp_vld, mem_rsp_data, dec_rdy,
        output instr_req_rdy, mem_req_vld, mem_req_addr,
               dec_vld, dec_instr, dec_pc, fetch_busy_o
    );

    modport master (
        output instr_req_pc, instr_req_vld, flush_i, mem_req_rdy,
               mem_rsp_vld, mem_rsp_data, dec_rdy,
        input  instr_req_rdy, mem_req_vld, mem_req_addr,
               dec_vld, dec_instr, dec_pc, fetch_busy_o
    );
endinterface

// File: rtl/ifu_fetch_queue.sv
// In-order fetch queue between PC generator, instruction memory and decoder.
// Define IFU_RSP_BYPASS_EN for zero-cycle response-to-decode forwarding.
module ifu_fetch_queue #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned DEPTH   = 4
) (
    input logic              clk,
    input logic              rst,
    ifu_fetch_queue_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    logic [ADDR_W-1:0]  pc_q    [DEPTH];
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [DEPTH-1:0]   filled_q, filled_d;
    ptr_t               alloc_q, alloc_d;
    ptr_t               fill_q, fill_d;
    ptr_t               head_q, head_d;
    ptr_t               drop_q, drop_d;

    ptr_t               occ, unfilled;
    logic [PW:0]        charge;
    logic [AW-1:0]      alloc_idx, fill_idx, head_idx;
    logic               credit, issue_ok, req_hs;
    logic               rsp_drop, rsp_fill, head_occ;
    logic               bypass, byp_pop, dec_vld_raw, pop;

    assign occ       = alloc_q - head_q;
    assign unfilled  = alloc_q - fill_q;
    assign charge    = {1'b0, occ} + {1'b0, drop_q};
    assign alloc_idx = alloc_q[AW-1:0];
    assign fill_idx  = fill_q[AW-1:0];
    assign head_idx  = head_q[AW-1:0];

    // Entries still owed a dropped response consume credit like live entries.
    assign credit   = charge < (PW+1)'(DEPTH);
    assign issue_ok = credit & ~bus.flush_i & ~rst;

    assign bus.mem_req_vld   = bus.instr_req_vld & issue_ok;
    assign bus.mem_req_addr  = bus.instr_req_pc;
    assign bus.instr_req_rdy = bus.mem_req_rdy & issue_ok;
    assign req_hs            = bus.instr_req_vld & bus.instr_req_rdy;

    assign rsp_drop = bus.mem_rsp_vld & (drop_q != '0);
    assign rsp_fill = bus.mem_rsp_vld & (drop_q == '0) & (unfilled != '0);
    assign head_occ = occ != '0;

`ifdef IFU_RSP_BYPASS_EN
    assign bypass = rsp_fill & head_occ & (head_q == fill_q);
`else
    assign bypass = 1'b0;
`endif

    assign dec_vld_raw   = (head_occ & filled_q[head_idx]) | bypass;
    assign pop           = dec_vld_raw & bus.dec_rdy;
    assign byp_pop       = bypass & bus.dec_rdy;
    assign bus.dec_vld   = dec_vld_raw & ~rst;
    assign bus.dec_instr = bypass ? bus.mem_rsp_data : instr_q[head_idx];
    assign bus.dec_pc    = pc_q[head_idx];
    assign bus.fetch_busy_o = ~rst & (head_occ | (drop_q != '0));

    always_comb begin
        alloc_d  = alloc_q;
        fill_d   = fill_q;
        head_d   = head_q;
        drop_d   = drop_q;
        filled_d = filled_q;

        if (req_hs) begin
            alloc_d             = alloc_q + ptr_t'(1);
            filled_d[alloc_idx] = 1'b0;
        end

        if (rsp_drop) begin
            drop_d = drop_q - ptr_t'(1);
        end else if (rsp_fill) begin
            fill_d = fill_q + ptr_t'(1);
            if (!byp_pop) begin
                filled_d[fill_idx] = 1'b1;
            end
        end

        if (pop) begin
            head_d             = head_q + ptr_t'(1);
            filled_d[head_idx] = 1'b0;
        end

        // A response arriving with the flush is already consumed, so it is not owed again.
        if (bus.flush_i) begin
            alloc_d  = alloc_q;
            fill_d   = alloc_q;
            head_d   = alloc_q;
            filled_d = '0;
            drop_d   = drop_q + unfilled - ptr_t'(rsp_drop | rsp_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_q  <= '0;
            fill_q   <= '0;
            head_q   <= '0;
            drop_q   <= '0;
            filled_q <= '0;
        end else begin
            alloc_q  <= alloc_d;
            fill_q   <= fill_d;
            head_q   <= head_d;
            drop_q   <= drop_d;
            filled_q <= filled_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_hs) begin
            pc_q[alloc_idx] <= bus.instr_req_pc;
        end
        if (rsp_fill) begin
            instr_q[fill_idx] <= bus.mem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.mem_rsp_vld && (drop_q == '0) && (unfilled == '0)))
                else $error("ifu_fetch_queue: response with nothing outstanding");
            assert (charge <= (PW+1)'(DEPTH))
                else $error("ifu_fetch_queue: occupancy plus drops exceeds depth");
        end
    end
endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
Instruction-fetch stage directly downstream of the PC generator.
- Accepts fetch requests (PC) and forwards them to the instruction-memory port.
- Tracks outstanding accesses in order and buffers returned instructions with their PC.
- Presents instructions to the decoder with valid/ready.
- Discards in-flight and buffered fetches when a redirect (jump) occurs, and provides the back-pressure that throttles PC issue.

Parameters:
- ADDR_W, 64: PC / fetch address width.
- INSTR_W, 32: instruction width.
- DEPTH, 4: queue entries and the maximum number of fetches in flight. Power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- instr_req_pc  in  ADDR_W  fetch PC from the PC stage.
- instr_req_vld  in  1  fetch request valid.
- instr_req_rdy  out  1  fetch request accepted this cycle when high with instr_req_vld.
- flush_i  in  1  redirect/jump; kills all older fetches.
- mem_req_vld  out  1  memory read request valid.
- mem_req_addr  out  ADDR_W  memory read address.
- mem_req_rdy  in  1  memory accepts request.
- mem_rsp_vld  in  1  memory response valid. In-order, always accepted.
- mem_rsp_data  in  INSTR_W  returned instruction.
- dec_vld  out  1  instruction valid to decoder.
- dec_instr  out  INSTR_W  instruction to decoder.
- dec_pc  out  ADDR_W  PC of dec_instr.
- dec_rdy  in  1  decoder accepts.
- fetch_busy_o  out  1  any entry occupied or any drop pending.

Behaviour:

Storage and pointers
- Circular queue of DEPTH entries, each holding {pc, instr, filled}.
- Pointers: alloc_ptr, fill_ptr, head_ptr, each log2(DEPTH)+1 bits with a wrap bit.
- occupancy = alloc_ptr − head_ptr.
- drop_cnt register, log2(DEPTH)+1 bits: number of in-flight responses still to be discarded.

Issue (combinational pass-through)
- credit = (occupancy + drop_cnt) < DEPTH.
- mem_req_vld = instr_req_vld & credit & ~flush_i & ~rst.
- mem_req_addr = instr_req_pc.
- instr_req_rdy = mem_req_rdy & credit & ~flush_i & ~rst.
- On handshake: write pc at alloc_ptr, clear filled, alloc_ptr++.

Response
- If mem_rsp_vld & drop_cnt≠0: discard the response, drop_cnt−−.
- Else if mem_rsp_vld: write instr at fill_ptr, set filled, fill_ptr++.
- mem_rsp_vld with no unfilled entry and drop_cnt=0 is a protocol error. Ignore it; assertion only.

Decode output
- dec_vld = head entry occupied & filled.
- dec_instr / dec_pc come from the head entry.
- Pop (head_ptr++) on dec_vld & dec_rdy.
- Latency from mem_rsp_vld to dec_vld is 1 cycle (registered).

Flush (priority over everything in the same cycle)
- Set head_ptr = fill_ptr = alloc_ptr; all entries invalidated. No request is issued that cycle.
- drop_cnt_next = drop_cnt + unfilled entries − (1 if mem_rsp_vld this cycle, whichever path consumed it).
- A response coinciding with flush counts as received and is not re-dropped.
- A pop coinciding with flush still completes at the decoder (dec_vld was already visible).

Boundary conditions
- Full (occupancy + drop_cnt = DEPTH): instr_req_rdy=0. Accept resumes the cycle after a pop or a dropped response.
- Pointer wrap: handled by the wrap bit; full and empty are distinguished by it.
- Back-to-back flushes: accumulate drop_cnt correctly; drop_cnt never exceeds DEPTH.

Reset
- All pointers 0, drop_cnt 0, filled bits 0.
- Outputs during and after reset: dec_vld=0, mem_req_vld=0, instr_req_rdy=0 (during rst), fetch_busy_o=0.
- Reset mid-operation abandons outstanding memory responses. The memory side is reset by the same rst.

Optional Feature:
IFU_RSP_BYPASS_EN
- Defined:
  - When the head entry is the one being filled this cycle (head_ptr = fill_ptr, occupied) and the response is not dropped, dec_vld=1 the same cycle with dec_instr=mem_rsp_data.
  - If dec_rdy, pop without marking the entry filled: fill_ptr++ and head_ptr++.
  - Zero-cycle response-to-decode latency.
- Undefined:
  - Purely registered path with 1-cycle latency as described above.

Test Plan:
- Reset, then request pc=0x80000000, mem_rsp_data=0x00000013 one cycle later → dec_vld=1, dec_pc=0x80000000, dec_instr=0x00000013 one cycle after response (same cycle with IFU_RSP_BYPASS_EN); fetch_busy_o falls after pop.
- dec_rdy=0, four consecutive requests 0x0/0x4/0x8/0xC, all responded → instr_req_rdy=0 on the 5th request; one pop → 5th accepted next cycle; output order 0x0,0x4,0x8,0xC.
- Issue 3 requests, no responses, flush_i=1 → drop_cnt=3, instr_req_rdy=0 that cycle; 3 responses discarded (dec_vld stays 0); new request 0x100 → its response delivered with dec_pc=0x100.
- Flush in the same cycle as the response to the oldest of 2 outstanding → drop_cnt=1; exactly one later response dropped.
- mem_req_rdy=0 for 3 cycles with instr_req_vld=1 → no allocation, instr_req_rdy=0, mem_req_addr stable; on mem_req_rdy=1 a single entry is allocated.
- Assert rst with 2 entries filled and 1 outstanding → next cycle dec_vld=0, fetch_busy_o=0, occupancy 0.
